alu_out_buffer: RTL and testbench
=================================

// Module: alu_out_buffer
// PURPOSE
//   Parametrised valid/ready FIFO that carries ALU result packets from the execute stage to writeback.
//   - Decouples ALU issue from writeback stalls.
//   - Supports configurable data width, depth, an optional zero-latency bypass, and a high-water flag.
//   - Supports a synchronous pipeline flush for branch/exception squash.
//   - Sits between the ALU result port and the writeback/regfile arbiter.
// PARAMETERS
//   DATA_W  64         width of one ALU result packet (bits)
//   DEPTH   4          number of entries; any value >= 2, power of two not required
//   BYPASS  0          1 = an empty FIFO forwards in_data to out_data in the same cycle
//   HWM     DEPTH-1    hi_water asserts when count >= HWM; legal range 1..DEPTH
//   CNT_W   $clog2(DEPTH+1)  derived width of count; not to be overridden
// PORTS
//   clk       in   1       rising-edge clock
//   reset     in   1       synchronous, active-high reset
//   flush     in   1       synchronous squash of all stored entries
//   in_valid  in   1       producer has a packet on in_data
//   in_ready  out  1       buffer accepts a packet this cycle
//   in_data   in   DATA_W  incoming ALU result packet
//   out_valid out  1       out_data holds a valid packet
//   out_ready in   1       consumer takes out_data this cycle
//   out_data  out  DATA_W  oldest packet (or bypassed in_data)
//   count     out  CNT_W   number of stored entries, 0..DEPTH
//   full      out  1       count == DEPTH
//   empty     out  1       count == 0
//   hi_water  out  1       count >= HWM
// BEHAVIOUR
//   - One clock (clk). Reset is synchronous and active-high.
//   - While reset=1, at the next edge: wr_ptr=0, rd_ptr=0, count=0.
//     - Outputs during and after reset: out_valid=0, in_ready=0 while reset=1; empty=1, full=0, hi_water=0.
//     - Storage array is not reset.
//   - Handshake rules:
//     - push = in_valid & in_ready
//     - pop = out_valid & out_ready
//     - in_ready = !full & !flush & !reset; it is combinational and independent of out_ready.
//   - Latency, BYPASS=0:
//     - out_valid = !empty & !flush.
//     - out_data = mem[rd_ptr].
//     - A packet pushed at edge N is visible from cycle N+1.
//   - Latency, BYPASS=1, when empty & in_valid & !flush:
//     - out_valid=1 and out_data=in_data, combinationally.
//     - If out_ready=1 too, the packet passes straight through: nothing is written, count stays 0.
//     - If out_ready=0, the packet is written (push) and presented from the array next cycle.
//   - Count update: count_next = count + push - pop (the bypass pass-through counts as neither).
//     - Push and pop in the same cycle leave count unchanged; both pointers advance.
//   - Pointers advance by 1 and wrap from DEPTH-1 to 0. Non-power-of-two DEPTH must wrap correctly.
//   - Full: in_ready=0, and in_valid is held off by the producer.
//     - A pop while full frees the slot only for the next cycle; there is no same-cycle refill.
//   - Empty: with BYPASS=0, out_valid=0 and the value of out_data is don't-care.
//   - Stability: while out_valid & !out_ready, out_data must not change.
//   - Flush (priority below reset, above push/pop):
//     - In the flush cycle, in_ready=0 and out_valid=0.
//     - At the edge, pointers and count go to 0. Any in_valid that cycle is discarded.
//   - Reset asserted mid-stream: all entries are discarded exactly as for flush. No partial packet survives.
//   - full, empty and hi_water are combinational decodes of the registered count.
//   - Simulation assertions:
//     - push never occurs when full.
//     - pop never occurs when empty (bypass excepted).
//     - count never exceeds DEPTH.
// TESTING
//   1. Reset, then 4 pushes 0xA0..0xA3 with out_ready=0 (DEPTH=4).
//      -> count 1,2,3,4; hi_water from count=3; full=1; in_ready=0.
//      -> Then out_ready=1 pops 0xA0,0xA1,0xA2,0xA3 in order; empty=1.
//   2. Continuous push+pop for 10 cycles, in_data=1..10, out_ready=1 (BYPASS=0).
//      -> count holds at 1; out_data sequence 1..10, each one cycle after push; pointers wrap twice.
//   3. BYPASS=1, empty, in_valid=1, in_data=0x55, out_ready=1.
//      -> out_valid=1 and out_data=0x55 in the same cycle; count stays 0.
//      -> Repeat with out_ready=0: count=1 next cycle, 0x55 is held stable until out_ready.
//   4. DEPTH=3: push 7 packets with interleaved pops.
//      -> Order is preserved across the wrap at index 2->0; full asserts only at count=3.
//   5. Buffer holds 3 entries; assert flush for 1 cycle with in_valid=1 and in_data=0xFF.
//      -> out_valid=0 and in_ready=0 that cycle; count=0 next cycle; 0xFF never appears on out_data.
//   6. Buffer holds 2 entries; assert reset for 1 cycle with out_ready=1.
//      -> No pop is seen; after reset count=0, empty=1, in_ready=1.

Source files
------------

// File: rtl/alu_out_buffer.sv
// Valid/ready FIFO carrying ALU result packets from execute to writeback.
// Optional same-cycle bypass when empty; synchronous flush squashes all entries.
module alu_out_buffer #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    parameter int BYPASS = 0,
    parameter int HWM    = DEPTH - 1,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              hi_water
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              byp_hit, pass_thru, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign hi_water = (count_q >= CNT_W'(HWM));
    assign in_ready = !full && !flush && !reset;

    // Bypass only ever fires on an empty buffer, so it never coincides with a real pop.
    assign byp_hit   = (BYPASS != 0) && empty && in_valid && !flush && !reset;
    assign out_valid = (!empty && !flush && !reset) || byp_hit;
    assign out_data  = byp_hit ? in_data : mem[rd_ptr];
    assign pass_thru = byp_hit && out_ready;
    assign push      = in_valid && in_ready && !pass_thru;
    assign pop       = out_valid && out_ready && !byp_hit;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is deliberately left unreset; push is already gated off by reset/flush.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

`ifndef SYNTHESIS
    a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(push && full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) !(pop && empty));
    a_cnt_max:      assert property (@(posedge clk) disable iff (reset) count_q <= CNT_W'(DEPTH));
`endif
endmodule

// File: tb/tb_alu_out_buffer.sv
// Three buffer configurations (D4, D4+bypass, D3) checked against queue models.
module tb_alu_out_buffer;
    logic clk = 1'b0;
    logic rst;
    logic [2:0]      iv, ordy, fl;
    logic [2:0][7:0] id;
    logic [2:0]      ir, ov, fullv, emptyv, hwv;
    logic [2:0][7:0] od;
    logic [2:0][2:0] cnt;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int D  = (g == 2) ? 3 : 4;
        localparam int B  = (g == 1) ? 1 : 0;
        localparam int CW = $clog2(D + 1);
        logic [CW-1:0] c;
        logic f, e, h, irl, ovl;
        logic [7:0] odl;

        alu_out_buffer #(.DATA_W(8), .DEPTH(D), .BYPASS(B)) u_dut (
            .clk(clk), .reset(rst), .flush(fl[g]),
            .in_valid(iv[g]), .in_ready(irl), .in_data(id[g]),
            .out_valid(ovl), .out_ready(ordy[g]), .out_data(odl),
            .count(c), .full(f), .empty(e), .hi_water(h)
        );
        assign ir[g] = irl;  assign ov[g] = ovl;  assign od[g] = odl;
        assign cnt[g] = 3'(c);
        assign fullv[g] = f; assign emptyv[g] = e; assign hwv[g] = h;

        logic [7:0] q[$];
        bit armed = 1'b0;

        // Reference: a plain queue; expected outputs follow from its size and the inputs.
        always @(negedge clk) begin
            int sz;
            logic e_ir, e_ov, byp;
            logic [7:0] e_od;
            sz = q.size();
            if (rst || fl[g]) begin
                e_ir = 1'b0; e_ov = 1'b0; byp = 1'b0;
            end else begin
                e_ir = (sz < D);
                byp  = (B != 0) && (sz == 0) && iv[g];
                e_ov = (sz > 0) || byp;
            end
            e_od = byp ? id[g] : ((sz > 0) ? q[0] : 8'h00);
            if (armed) begin
                chk($sformatf("i%0d in_ready", g), int'(ir[g]), int'(e_ir));
                chk($sformatf("i%0d out_valid", g), int'(ov[g]), int'(e_ov));
                if (e_ov) chk($sformatf("i%0d out_data", g), int'(od[g]), int'(e_od));
                chk($sformatf("i%0d count", g), int'(cnt[g]), sz);
                chk($sformatf("i%0d full", g), int'(fullv[g]), int'(sz == D));
                chk($sformatf("i%0d empty", g), int'(emptyv[g]), int'(sz == 0));
                chk($sformatf("i%0d hi_water", g), int'(hwv[g]), int'(sz >= D - 1));
            end
            if (rst) begin
                q.delete();
                armed = 1'b1;
            end else if (fl[g]) begin
                q.delete();
            end else if (byp) begin
                if (!ordy[g]) q.push_back(id[g]);
            end else begin
                if (e_ov && ordy[g]) void'(q.pop_front());
                if (iv[g] && e_ir) q.push_back(id[g]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        iv = '0; ordy = '0; fl = '0; id = '0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        settle();
        chk("reset empty", int'(emptyv[0]), 1);
        chk("reset count", int'(cnt[0]), 0);
        chk("reset in_ready", int'(ir[0]), 1);

        // Fill DEPTH=4, then drain in order
        for (int i = 0; i < 4; i++) begin
            iv[0] = 1'b1; id[0] = 8'hA0 + 8'(i);
            step();
            iv[0] = 1'b0;
            settle();
            chk("t1 count", int'(cnt[0]), i + 1);
            chk("t1 hi_water", int'(hwv[0]), int'(i + 1 >= 3));
        end
        chk("t1 full", int'(fullv[0]), 1);
        chk("t1 in_ready", int'(ir[0]), 0);
        for (int i = 0; i < 4; i++) begin
            ordy[0] = 1'b1;
            settle();
            chk("t1 pop data", int'(od[0]), 'hA0 + i);
            step();
        end
        ordy[0] = 1'b0;
        settle();
        chk("t1 drained empty", int'(emptyv[0]), 1);

        // Streaming push+pop, count holds at 1
        for (int k = 1; k <= 10; k++) begin
            iv[0] = 1'b1; ordy[0] = 1'b1; id[0] = 8'(k);
            settle();
            if (k > 1) begin
                chk("t2 out_data", int'(od[0]), k - 1);
                chk("t2 count", int'(cnt[0]), 1);
            end
            step();
        end
        iv[0] = 1'b0;
        settle();
        chk("t2 last", int'(od[0]), 10);
        step();
        ordy[0] = 1'b0;

        // Bypass pass-through and bypass-then-hold
        iv[1] = 1'b1; id[1] = 8'h55; ordy[1] = 1'b1;
        settle();
        chk("t3 byp valid", int'(ov[1]), 1);
        chk("t3 byp data", int'(od[1]), 'h55);
        step();
        iv[1] = 1'b0;
        settle();
        chk("t3 byp count", int'(cnt[1]), 0);
        iv[1] = 1'b1; id[1] = 8'h55; ordy[1] = 1'b0;
        settle();
        chk("t3 hold valid", int'(ov[1]), 1);
        step();
        iv[1] = 1'b0; id[1] = 8'h12;
        settle();
        chk("t3 hold count", int'(cnt[1]), 1);
        chk("t3 hold data", int'(od[1]), 'h55);
        step();
        chk("t3 stable data", int'(od[1]), 'h55);
        ordy[1] = 1'b1;
        step();
        ordy[1] = 1'b0;
        settle();
        chk("t3 drained", int'(cnt[1]), 0);

        // DEPTH=3 wrap with interleaved pops
        for (int i = 0; i < 3; i++) begin
            iv[2] = 1'b1; id[2] = 8'h10 + 8'(i);
            step();
            iv[2] = 1'b0;
            settle();
            chk("t4 full", int'(fullv[2]), int'(i == 2));
        end
        ordy[2] = 1'b1;
        settle();
        chk("t4 pop 10", int'(od[2]), 'h10);
        step();
        ordy[2] = 1'b0; iv[2] = 1'b1; id[2] = 8'h13;
        step();
        iv[2] = 1'b0;
        settle();
        chk("t4 refull", int'(fullv[2]), 1);
        for (int i = 1; i < 4; i++) begin
            ordy[2] = 1'b1;
            settle();
            chk("t4 pop order", int'(od[2]), 'h10 + i);
            step();
        end
        for (int i = 4; i < 7; i++) begin
            iv[2] = 1'b1; ordy[2] = 1'b1; id[2] = 8'h10 + 8'(i);
            step();
        end
        idle();
        step();

        // Flush with 3 entries and a discarded 0xFF
        for (int i = 0; i < 3; i++) begin
            iv[0] = 1'b1; id[0] = 8'hC0 + 8'(i);
            step();
        end
        fl[0] = 1'b1; iv[0] = 1'b1; id[0] = 8'hFF;
        settle();
        chk("t5 flush out_valid", int'(ov[0]), 0);
        chk("t5 flush in_ready", int'(ir[0]), 0);
        step();
        idle();
        settle();
        chk("t5 count", int'(cnt[0]), 0);
        chk("t5 out_valid", int'(ov[0]), 0);
        step();

        // Reset mid-stream with consumer ready
        for (int i = 0; i < 2; i++) begin
            iv[0] = 1'b1; id[0] = 8'hD0 + 8'(i);
            step();
        end
        iv[0] = 1'b0; rst = 1'b1; ordy[0] = 1'b1;
        settle();
        chk("t6 no pop", int'(ov[0]), 0);
        step();
        rst = 1'b0; ordy[0] = 1'b0;
        settle();
        chk("t6 count", int'(cnt[0]), 0);
        chk("t6 empty", int'(emptyv[0]), 1);
        chk("t6 in_ready", int'(ir[0]), 1);

        // Random traffic on all three configurations
        for (int n = 0; n < 2000; n++) begin
            for (int g = 0; g < 3; g++) begin
                iv[g]   = 1'($urandom_range(0, 1));
                ordy[g] = 1'($urandom_range(0, 2) != 0);
                fl[g]   = 1'($urandom_range(0, 31) == 0);
                id[g]   = 8'($urandom);
            end
            rst = 1'($urandom_range(0, 199) == 0);
            step();
        end
        idle();
        rst = 1'b0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
